pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. Operands are split into BLOCK-bit lookahead groups. Each group is resolved in its own pipeline stage, with carry registered between groups, so the critical path is one group. It is the reusable wide-adder datapath block for ALU and accumulator designs in the adders library.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/cla_group.sv | 62 ++++++
 rtl/pipelined_cla_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder family.
// A group result carries the group sum plus its propagate/generate terms.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLOCK = 4;
    localparam int MAX_BLOCK = 64;

    // The sum field is sized for the widest supported group; narrower groups use the low bits.
    typedef struct packed {
        logic [MAX_BLOCK-1:0] sum;
        logic                 p;
        logic                 g;
        logic                 cout;
    } grp_res_t;

    function automatic int ngroups(input int width, input int block);
        return (block < 1) ? 0 : width / block;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group: every internal carry is a
// flat sum-of-products of generate/propagate terms and the group carry-in.
module cla_group
    import adder_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] bx,
    input  logic             cin,
    output grp_res_t         res
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] c;
    logic             grp_g;
    logic             grp_p;
    logic             term;
    logic             acc;

    assign p     = a ^ bx;
    assign g     = a & bx;
    assign grp_p = &p;

    always_comb begin
        c     = '0;
        grp_g = 1'b0;
        term  = 1'b0;
        acc   = 1'b0;
        c[0]  = cin;
        // Carry into bit i: OR of g[j] & p[j+1..i-1], plus cin & p[0..i-1].
        for (int i = 1; i <= BLOCK; i++) begin
            acc = 1'b0;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            if (i == BLOCK) begin
                grp_g = acc;
            end else begin
                term = cin;
                for (int m = 0; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = acc | term;
            end
        end
    end

    always_comb begin
        res                  = '0;
        res.sum[BLOCK-1:0]   = p ^ c;
        res.p                = grp_p;
        res.g                = grp_g;
        res.cout             = grp_g | (grp_p & cin);
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group per stage,
// carry registered between groups, valid/ready stream with a global stall.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG         = ngroups(WIDTH, BLOCK);
    localparam int SAFE_BLOCK = (BLOCK < 1) ? 1 : BLOCK;

    if (BLOCK < 1 || BLOCK > MAX_BLOCK || WIDTH < SAFE_BLOCK || (WIDTH % SAFE_BLOCK) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK (1..64)");
    end

    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] bx_in;
    logic             ovf_n;
    logic             ovf_p;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign bx_in    = sub ? ~b : b;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] ain;
        logic [WIDTH-1:0] bin;
        logic [WIDTH-1:0] sin;
        logic             gc;
        logic [BLOCK-1:0] ga;
        logic [BLOCK-1:0] gb;
        logic [WIDTH-1:0] nsum;
        grp_res_t         gres;
        logic             unused_grp;
        logic             vld_p;
        logic [WIDTH-1:0] sum_p;
        logic             c_p;

        if (k == 0) begin : g_src
            assign vin = in_valid;
            assign ain = a;
            assign bin = bx_in;
            assign sin = '0;
            assign gc  = sub | cin;
        end else begin : g_src
            assign vin = g_stage[k-1].vld_p;
            assign ain = g_stage[k-1].g_skew.a_p;
            assign bin = g_stage[k-1].g_skew.bx_p;
            assign sin = g_stage[k-1].sum_p;
            assign gc  = g_stage[k-1].c_p;
        end

        assign ga = ain[k*BLOCK +: BLOCK];
        assign gb = bin[k*BLOCK +: BLOCK];

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a   (ga),
            .bx  (gb),
            .cin (gc),
            .res (gres)
        );

        assign unused_grp = ^{gres.p, gres.g, gres.sum};

        always_comb begin
            nsum                     = sin;
            nsum[k*BLOCK +: BLOCK]   = gres.sum[BLOCK-1:0];
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                sum_p <= '0;
                c_p   <= 1'b0;
            end else if (advance) begin
                vld_p <= vin;
                sum_p <= nsum;
                c_p   <= gres.cout;
            end
        end

        // Operands still needed by later groups ride along with the beat.
        if (k < NG - 1) begin : g_skew
            logic [WIDTH-1:0] a_p;
            logic [WIDTH-1:0] bx_p;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_p  <= '0;
                    bx_p <= '0;
                end else if (advance) begin
                    a_p  <= ain;
                    bx_p <= bin;
                end
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ovf_n = signed_ovf(g_stage[NG-1].gres.sum[BLOCK-1] ^ g_stage[NG-1].ga[BLOCK-1]
                              ^ g_stage[NG-1].gb[BLOCK-1],
                              g_stage[NG-1].gres.cout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p <= 1'b0;
        end else if (advance) begin
            ovf_p <= ovf_n;
        end
    end

    assign out_valid = g_stage[NG-1].vld_p;
    assign sum       = g_stage[NG-1].sum_p;
    assign cout      = g_stage[NG-1].c_p;
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: latency, streaming, backpressure,
// mid-stream reset, plus a scoreboarded sweep on 8/4 and 32/8 instances.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid_x, cin_x, sub_x, out_ready_x;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    int n_asrt = 0;
    int n_fail = 0;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(8), .BLOCK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin_x), .sub(sub_x), .out_valid(out_valid8),
        .out_ready(out_ready_x), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin_x), .sub(sub_x), .out_valid(out_valid32),
        .out_ready(out_ready_x), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = c;
        sub      = s;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] s,
                             input logic co, input logic ov);
        check({tag, "_vld"},  64'(out_valid), 64'(v));
        check({tag, "_sum"},  64'(sum),       64'(s));
        check({tag, "_cout"}, 64'(cout),      64'(co));
        check({tag, "_ovf"},  64'(ovf),       64'(ov));
    endtask

    // Reference result packed as {ovf, cout, sum}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] av, input logic [63:0] bv,
                                            input logic c, input logic s);
        logic [63:0] mask, bx, tot, sm;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        bx   = (s ? ~bv : bv) & mask;
        tot  = av + bx + 64'(s ? 1'b1 : c);
        sm   = tot & mask;
        co   = tot[w];
        ov   = (av[w-1] == bx[w-1]) && (sm[w-1] != av[w-1]);
        return {ov, co, sm};
    endfunction

    logic [65:0] q8  [$];
    logic [65:0] q32 [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [65:0] e;
        int          n8, n32;
        n8  = 0;
        n32 = 0;

        vt[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[1] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
        vt[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_x = 1'b0; a8 = '0; b8 = '0; a32 = '0; b32 = '0; cin_x = 1'b0; sub_x = 1'b0;
        out_ready_x = 1'b1;
        tick();
        tick();

        check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_vld8", 64'(out_valid8), 64'd0);
        check("reset_vld32", 64'(out_valid32), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_vld", 64'(out_valid), 64'd0);

        // Latency: result must appear exactly four edges after accept.
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("lat_early_vld", 64'(out_valid), 64'd0);
            tick();
        end
        check_out("lat", 1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        check("lat_drain_vld", 64'(out_valid), 64'd0);

        // Back-to-back stream of the directed vectors.
        for (int t = 0; t < 12; t++) begin
            if (t >= 4) check_out("stream", 1'b1, vt[t-4].s, vt[t-4].co, vt[t-4].ov);
            else        check("stream_idle_vld", 64'(out_valid), 64'd0);
            if (t < 8) begin
                drive(vt[t].a, vt[t].b, vt[t].cin, vt[t].sub);
                check("stream_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("stream_end_vld", 64'(out_valid), 64'd0);

        // Backpressure: X then Y in flight, Z offered while stalled.
        drive(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        tick();
        drive(16'hA000, 16'h6000, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(16'h0003, 16'h0004, 1'b1, 1'b0);
            #1;
            check_out("bp_hold", 1'b1, 16'h1000, 1'b0, 1'b0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check_out("bp_last", 1'b1, 16'h1000, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check_out("bp_y", 1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        check("bp_bubble1_vld", 64'(out_valid), 64'd0);
        tick();
        check("bp_bubble2_vld", 64'(out_valid), 64'd0);
        tick();
        check_out("bp_z", 1'b1, 16'h0008, 1'b0, 1'b0);
        tick();
        check("bp_end_vld", 64'(out_valid), 64'd0);

        // Reset with three beats in flight.
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h8000, 16'h8000, 1'b0, 1'b0);
        tick();
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_out("midrst", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_stale_vld", 64'(out_valid), 64'd0);
        end

        // Sweep on the 8/4 and 32/8 instances against the reference sum.
        for (int t = 0; t < 26; t++) begin
            if (out_valid8) begin
                n8++;
                if (q8.size() == 0) begin
                    check("sw8_extra", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    check("sw8_sum",  64'(sum8),  64'(e[7:0]));
                    check("sw8_cout", 64'(cout8), 64'(e[64]));
                    check("sw8_ovf",  64'(ovf8),  64'(e[65]));
                end
            end
            if (out_valid32) begin
                n32++;
                if (q32.size() == 0) begin
                    check("sw32_extra", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("sw32_sum",  64'(sum32),  64'(e[31:0]));
                    check("sw32_cout", 64'(cout32), 64'(e[64]));
                    check("sw32_ovf",  64'(ovf32),  64'(e[65]));
                end
            end
            if (t < 20) begin
                in_valid_x = 1'b1;
                a8    = (t == 0) ? 8'h7F : 8'($urandom);
                b8    = (t == 0) ? 8'h01 : 8'($urandom);
                a32   = (t == 1) ? 32'h8000_0000 : $urandom;
                b32   = (t == 1) ? 32'h0000_0001 : $urandom;
                cin_x = (t == 0) ? 1'b0 : 1'($urandom);
                sub_x = (t == 1) ? 1'b1 : (t == 0) ? 1'b0 : 1'($urandom);
                check("sw8_in_ready", 64'(in_ready8), 64'd1);
                q8.push_back(ref_add(8, 64'(a8), 64'(b8), cin_x, sub_x));
                q32.push_back(ref_add(32, 64'(a32), 64'(b32), cin_x, sub_x));
            end else begin
                in_valid_x = 1'b0;
            end
            tick();
        end
        check("sw8_count", 64'(n8), 64'd20);
        check("sw32_count", 64'(n32), 64'd20);
        check("sw8_left", 64'(q8.size()), 64'd0);
        check("sw32_left", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
